// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
// Groups the instruction/memory handshake and the datapath control bundle of
// the multi-cycle control unit.
//   master : control unit side (receives opcode/mem_ready/stall, drives controls)
//   slave  : datapath/memory side (drives opcode/mem_ready/stall, receives controls)
// Signals:
//   opcode[OPCODE_W]  instruction opcode field from memory
//   mem_ready, stall  memory completion and pipeline freeze
//   mem_req, ir_write, pc_write, regDst, branch, memRead, memWrite, ALUsrc,
//   regWrite, jump, byteOperations, move, ALUop[ALUOP_W]  datapath controls
//   state[3], illegal, timeout, instr_done  debug / trap / retire status
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 3
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                stall;
   logic                mem_req;
   logic                ir_write;
   logic                pc_write;
   logic                regDst;
   logic                branch;
   logic                memRead;
   logic                memWrite;
   logic [ALUOP_W-1:0]  ALUop;
   logic                ALUsrc;
   logic                regWrite;
   logic                jump;
   logic                byteOperations;
   logic                move;
   logic [2:0]          state;
   logic                illegal;
   logic                timeout;
   logic                instr_done;

   modport master (
      input  opcode, mem_ready, stall,
      output mem_req, ir_write, pc_write, regDst, branch, memRead, memWrite,
             ALUop, ALUsrc, regWrite, jump, byteOperations, move,
             state, illegal, timeout, instr_done
   );

   modport slave (
      output opcode, mem_ready, stall,
      input  mem_req, ir_write, pc_write, regDst, branch, memRead, memWrite,
             ALUop, ALUsrc, regWrite, jump, byteOperations, move,
             state, illegal, timeout, instr_done
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) for the multi-cycle
// CPU. Steps each instruction through its phases, waits on a variable-latency
// memory handshake with an optional timeout, honours a global stall and traps
// on illegal opcodes.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    multicycle_control_unit_if.master (opcode/mem_ready/stall in,
//          datapath controls, state, illegal, timeout, instr_done out)
//   retired_cnt[32]  retired-instruction counter, present only when the
//          MCU_PERF_CNT_EN macro is defined
// Control outputs are combinational from the current state and the latched
// opcode (plus mem_ready/stall for the handshake-qualified strobes).
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   multicycle_control_unit_if.master bus
`ifdef MCU_PERF_CNT_EN
   ,
   output logic [31:0]               retired_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b000011);
   localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b001001);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b010000);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b010001);
   localparam logic [OPCODE_W-1:0] OP_LB    = OPCODE_W'(6'b010010);
   localparam logic [OPCODE_W-1:0] OP_SB    = OPCODE_W'(6'b010011);
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b100000);
   localparam logic [OPCODE_W-1:0] OP_MOVE  = OPCODE_W'(6'b111000);

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b011);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b100);
   localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b101);

   localparam bit               TIMEOUT_EN  = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   state_t              state_r;
   logic [CNT_W-1:0]    wait_cnt_r;
   logic [OPCODE_W-1:0] opcode_q_r;
   logic                timeout_r;

   logic                is_rtype_s;
   logic                is_imm_s;
   logic                is_branch_s;
   logic                is_load_s;
   logic                is_store_s;
   logic                is_byte_s;
   logic                is_jump_s;
   logic                is_move_s;
   logic                is_legal_s;
   logic [ALUOP_W-1:0]  alu_op_s;
   logic                timeout_hit_s;
   logic                wr_en_s;

   // Wait budget exhausted this cycle; mem_ready is checked first by the FSM so it wins.
   assign timeout_hit_s = TIMEOUT_EN && (wait_cnt_r == TIMEOUT_CNT);
   // Write enables and retire pulses are only allowed while not stalled.
   assign wr_en_s       = ~bus.stall;

   // Classify the latched opcode into instruction groups and pick its ALU op.
   always_comb begin
      is_rtype_s  = 1'b0;
      is_imm_s    = 1'b0;
      is_branch_s = 1'b0;
      is_load_s   = 1'b0;
      is_store_s  = 1'b0;
      is_byte_s   = 1'b0;
      is_jump_s   = 1'b0;
      is_move_s   = 1'b0;
      is_legal_s  = 1'b1;
      alu_op_s    = ALU_ADD;
      case (opcode_q_r)
         OP_RTYPE: begin is_rtype_s = 1'b1; alu_op_s = ALU_FUNCT; end
         OP_ADDI:  begin is_imm_s = 1'b1; end
         OP_ANDI:  begin is_imm_s = 1'b1; alu_op_s = ALU_AND; end
         OP_ORI:   begin is_imm_s = 1'b1; alu_op_s = ALU_OR; end
         OP_SLTI:  begin is_imm_s = 1'b1; alu_op_s = ALU_SLT; end
         OP_BEQ,
         OP_BNE:   begin is_branch_s = 1'b1; alu_op_s = ALU_SUB; end
         OP_LW:    begin is_load_s = 1'b1; end
         OP_SW:    begin is_store_s = 1'b1; end
         OP_LB:    begin is_load_s = 1'b1; is_byte_s = 1'b1; end
         OP_SB:    begin is_store_s = 1'b1; is_byte_s = 1'b1; end
         OP_J:     begin is_jump_s = 1'b1; end
         OP_MOVE:  begin is_move_s = 1'b1; end
         default:  begin is_legal_s = 1'b0; end
      endcase
   end

   // Phase sequencing, memory wait counter, opcode latch and trap cause; all hold while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_FETCH;
         wait_cnt_r <= '0;
         opcode_q_r <= '0;
         timeout_r  <= 1'b0;
      end else if (!bus.stall) begin
         case (state_r)
            S_FETCH: begin
               if (bus.mem_ready) begin
                  opcode_q_r <= bus.opcode;
                  state_r    <= S_DECODE;
                  wait_cnt_r <= '0;
               end else if (timeout_hit_s) begin
                  state_r    <= S_TRAP;
                  timeout_r  <= 1'b1;
                  wait_cnt_r <= '0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               end
            end
            S_DECODE: begin
               wait_cnt_r <= '0;
               if (!is_legal_s) begin
                  state_r <= S_TRAP;
               end else if (is_jump_s) begin
                  state_r <= S_FETCH;
               end else begin
                  state_r <= S_EXEC;
               end
            end
            S_EXEC: begin
               wait_cnt_r <= '0;
               if (is_branch_s) begin
                  state_r <= S_FETCH;
               end else if (is_load_s || is_store_s) begin
                  state_r <= S_MEM;
               end else begin
                  state_r <= S_WB;
               end
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  state_r    <= is_load_s ? S_WB : S_FETCH;
                  wait_cnt_r <= '0;
               end else if (timeout_hit_s) begin
                  state_r    <= S_TRAP;
                  timeout_r  <= 1'b1;
                  wait_cnt_r <= '0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               end
            end
            S_WB: begin
               wait_cnt_r <= '0;
               state_r    <= S_FETCH;
            end
            S_TRAP: begin
               state_r <= S_TRAP;
            end
            default: begin
               // Unreachable encodings are treated as a fault.
               state_r    <= S_TRAP;
               wait_cnt_r <= '0;
            end
         endcase
      end
   end

   // Datapath controls decoded from the current phase and the latched opcode.
   always_comb begin
      bus.mem_req        = 1'b0;
      bus.ir_write       = 1'b0;
      bus.pc_write       = 1'b0;
      bus.regDst         = 1'b0;
      bus.branch         = 1'b0;
      bus.memRead        = 1'b0;
      bus.memWrite       = 1'b0;
      bus.ALUop          = ALU_ADD;
      bus.ALUsrc         = 1'b0;
      bus.regWrite       = 1'b0;
      bus.jump           = 1'b0;
      bus.byteOperations = 1'b0;
      bus.move           = 1'b0;
      bus.illegal        = 1'b0;
      bus.instr_done     = 1'b0;
      case (state_r)
         S_FETCH: begin
            bus.mem_req  = 1'b1;
            bus.memRead  = 1'b1;
            bus.ir_write = bus.mem_ready & wr_en_s;
            bus.pc_write = bus.mem_ready & wr_en_s;
         end
         S_DECODE: begin
            bus.jump       = is_jump_s;
            bus.pc_write   = is_jump_s & wr_en_s;
            bus.instr_done = is_jump_s & wr_en_s;
         end
         S_EXEC: begin
            bus.ALUsrc         = is_imm_s | is_load_s | is_store_s;
            bus.regDst         = is_rtype_s | is_move_s;
            bus.byteOperations = is_byte_s;
            bus.move           = is_move_s;
            bus.ALUop          = alu_op_s;
            // Branch PC update is qualified by zero/!zero in the datapath.
            bus.branch         = is_branch_s;
            bus.pc_write       = is_branch_s & wr_en_s;
            bus.instr_done     = is_branch_s & wr_en_s;
         end
         S_MEM: begin
            // Address operands stay selected for the whole access.
            bus.mem_req        = 1'b1;
            bus.ALUsrc         = 1'b1;
            bus.ALUop          = ALU_ADD;
            bus.memRead        = is_load_s;
            bus.memWrite       = is_store_s & wr_en_s;
            bus.byteOperations = is_byte_s;
            bus.instr_done     = is_store_s & bus.mem_ready & wr_en_s;
         end
         S_WB: begin
            // byteOperations/move keep selecting the write-back data source.
            bus.regWrite       = wr_en_s;
            bus.regDst         = is_rtype_s | is_move_s;
            bus.byteOperations = is_byte_s;
            bus.move           = is_move_s;
            bus.instr_done     = wr_en_s;
         end
         S_TRAP: begin
            bus.illegal = 1'b1;
         end
         default: begin
            bus.illegal = 1'b0;
         end
      endcase
   end

   assign bus.state   = state_r;
   assign bus.timeout = timeout_r;

`ifdef MCU_PERF_CNT_EN
   // Retired-instruction count; instr_done is already 0 in TRAP and under stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_cnt <= 32'd0;
      end else if (bus.instr_done) begin
         retired_cnt <= retired_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_ANDI = 6'b000011;
   localparam logic [5:0] OP_ORI  = 6'b000100;
   localparam logic [5:0] OP_SLTI = 6'b000101;
   localparam logic [5:0] OP_BEQ  = 6'b001000;
   localparam logic [5:0] OP_BNE  = 6'b001001;
   localparam logic [5:0] OP_LW   = 6'b010000;
   localparam logic [5:0] OP_SW   = 6'b010001;
   localparam logic [5:0] OP_LB   = 6'b010010;
   localparam logic [5:0] OP_SB   = 6'b010011;
   localparam logic [5:0] OP_J    = 6'b100000;
   localparam logic [5:0] OP_MOVE = 6'b111000;

   typedef struct packed {
      logic [2:0] state;
      logic       mem_req;
      logic       ir_write;
      logic       pc_write;
      logic       reg_dst;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic       jump;
      logic       byte_ops;
      logic       mv;
      logic [2:0] alu_op;
      logic       illegal;
      logic       timeout;
      logic       instr_done;
   } ctl_t;

   typedef struct {
      logic [5:0] op;
      int         mem_lat;
      int         cycles;
      logic [6:0] exec_ctl;   // {ALUop, ALUsrc, regDst, byteOperations, move} seen in EXEC
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_ret = 0;
   logic [5:0] legal_ops [13];

   always #5 clk = ~clk;

   multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(3)) bus ();

`ifdef MCU_PERF_CNT_EN
   logic [31:0] retired_cnt;
`endif

   multicycle_control_unit #(
      .OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(15), .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef MCU_PERF_CNT_EN
      ,
      .retired_cnt(retired_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic ctl_t dut_ctl();
      ctl_t c;
      c.state      = bus.state;
      c.mem_req    = bus.mem_req;
      c.ir_write   = bus.ir_write;
      c.pc_write   = bus.pc_write;
      c.reg_dst    = bus.regDst;
      c.branch     = bus.branch;
      c.mem_read   = bus.memRead;
      c.mem_write  = bus.memWrite;
      c.alu_src    = bus.ALUsrc;
      c.reg_write  = bus.regWrite;
      c.jump       = bus.jump;
      c.byte_ops   = bus.byteOperations;
      c.mv         = bus.move;
      c.alu_op     = bus.ALUop;
      c.illegal    = bus.illegal;
      c.timeout    = bus.timeout;
      c.instr_done = bus.instr_done;
      return c;
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [2:0] alu_for(input logic [5:0] op);
      case (op)
         OP_R:           return 3'b010;
         OP_ANDI:        return 3'b011;
         OP_ORI:         return 3'b100;
         OP_SLTI:        return 3'b101;
         OP_BEQ, OP_BNE: return 3'b001;
         default:        return 3'b000;
      endcase
   endfunction

   // Expected outputs for one cycle of a given phase of instruction op.
   function automatic ctl_t spec_ctl(input int ph, input logic [5:0] op, input bit rdy,
                                     input bit stl, input bit tmo);
      ctl_t c;
      bit ld, st, imm, br, byt, mvo, rdst;
      c   = '0;
      ld  = op inside {OP_LW, OP_LB};
      st  = op inside {OP_SW, OP_SB};
      imm = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
      br  = op inside {OP_BEQ, OP_BNE};
      byt = op inside {OP_LB, OP_SB};
      mvo = (op == OP_MOVE);
      rdst = (op == OP_R) || mvo;
      c.state = 3'(ph);
      case (ph)
         0: begin
            c.mem_req = 1'b1; c.mem_read = 1'b1;
            c.ir_write = rdy & !stl; c.pc_write = rdy & !stl;
         end
         1: if (op == OP_J) begin
            c.jump = 1'b1; c.pc_write = !stl; c.instr_done = !stl;
         end
         2: begin
            c.alu_src = imm | ld | st; c.reg_dst = rdst; c.byte_ops = byt; c.mv = mvo;
            c.alu_op = alu_for(op);
            if (br) begin c.branch = 1'b1; c.pc_write = !stl; c.instr_done = !stl; end
         end
         3: begin
            c.mem_req = 1'b1; c.mem_read = ld; c.mem_write = st & !stl; c.byte_ops = byt;
            c.alu_src = 1'b1; c.instr_done = st & rdy & !stl;
         end
         4: begin
            c.reg_write = !stl; c.reg_dst = rdst; c.instr_done = !stl; c.byte_ops = byt; c.mv = mvo;
         end
         7: begin c.illegal = 1'b1; c.timeout = tmo; end
         default: c = '0;
      endcase
      return c;
   endfunction

   // One clock cycle: drive inputs at negedge, compare 1 time unit later.
   task automatic cyc(input int ph, input logic [5:0] op, input bit rdy, input bit stl,
                      input bit tmo, input string nm);
      ctl_t e;
      @(negedge clk);
      bus.opcode    = (ph == 0) ? op : 6'($urandom);
      bus.mem_ready = rdy;
      bus.stall     = stl;
      #1;
      e = spec_ctl(ph, op, rdy, stl, tmo);
      chk(nm, 32'(dut_ctl()), 32'(e));
      if (e.instr_done) n_ret++;
   endtask

   // A phase cycle optionally preceded by a few random stall cycles.
   task automatic pcyc(input int ph, input logic [5:0] op, input bit rdy, input int spct,
                       input string nm);
      int ns;
      ns = ($urandom_range(0, 99) < spct) ? int'($urandom_range(1, 3)) : 0;
      for (int i = 0; i < ns; i++) cyc(ph, op, 1'($urandom), 1'b1, 1'b0, {nm, "_stall"});
      cyc(ph, op, rdy, 1'b0, 1'b0, nm);
   endtask

   // Whole instruction from the spec's phase list for its class.
   task automatic run_instr(input logic [5:0] op, input int flat, input int mlat, input int spct);
      for (int i = 0; i < flat; i++) pcyc(0, op, 1'b0, spct, "fetch_wait");
      pcyc(0, op, 1'b1, spct, "fetch");
      pcyc(1, op, 1'($urandom), spct, "decode");
      if (!is_legal(op)) begin
         for (int i = 0; i < 20; i++) cyc(7, op, 1'($urandom), 1'($urandom), 1'b0, "trap_illegal");
         return;
      end
      if (op == OP_J) return;
      pcyc(2, op, 1'($urandom), spct, "exec");
      if (op inside {OP_BEQ, OP_BNE}) return;
      if (op inside {OP_LW, OP_SW, OP_LB, OP_SB}) begin
         for (int i = 0; i < mlat; i++) pcyc(3, op, 1'b0, spct, "mem_wait");
         pcyc(3, op, 1'b1, spct, "mem");
         if (op inside {OP_SW, OP_SB}) return;
      end
      pcyc(4, op, 1'($urandom), spct, "wb");
   endtask

   // Reset, check the reset outputs, release with stall held so FETCH starts clean.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; bus.mem_ready = 1'b0; bus.stall = 1'b0;
      #1;
      chk("reset_state", 32'(dut_ctl()), 32'(spec_ctl(0, 6'd0, 1'b0, 1'b0, 1'b0)));
      bus.stall = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_ret = 0;
   endtask

   task automatic chk_perf(input string nm);
`ifdef MCU_PERF_CNT_EN
      chk(nm, retired_cnt, 32'(n_ret));
`else
      n_ret = n_ret + 0;
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      vec_t tbl [13];
      legal_ops = '{OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_BEQ, OP_BNE,
                    OP_LW, OP_SW, OP_LB, OP_SB, OP_J, OP_MOVE};
      tbl[0]  = '{OP_R,    0, 4, 7'b010_0_1_0_0};
      tbl[1]  = '{OP_ADDI, 0, 4, 7'b000_1_0_0_0};
      tbl[2]  = '{OP_ANDI, 0, 4, 7'b011_1_0_0_0};
      tbl[3]  = '{OP_ORI,  0, 4, 7'b100_1_0_0_0};
      tbl[4]  = '{OP_SLTI, 0, 4, 7'b101_1_0_0_0};
      tbl[5]  = '{OP_BEQ,  0, 3, 7'b001_0_0_0_0};
      tbl[6]  = '{OP_BNE,  0, 3, 7'b001_0_0_0_0};
      tbl[7]  = '{OP_LW,   3, 8, 7'b000_1_0_0_0};
      tbl[8]  = '{OP_SW,   0, 4, 7'b000_1_0_0_0};
      tbl[9]  = '{OP_LB,   1, 6, 7'b000_1_0_1_0};
      tbl[10] = '{OP_SB,   2, 6, 7'b000_1_0_1_0};
      tbl[11] = '{OP_J,    0, 2, 7'b000_0_0_0_0};
      tbl[12] = '{OP_MOVE, 0, 4, 7'b000_0_1_0_1};

      reset = 1'b1; bus.opcode = 6'd0; bus.mem_ready = 1'b0; bus.stall = 1'b0;
      do_reset();

      // Table: latency to retire and EXEC-phase controls per opcode.
      for (int v = 0; v < 13; v++) begin
         ctl_t ex;
         int   ncyc, mc;
         bit   done;
         ex = '0; ncyc = 0; mc = 0; done = 1'b0;
         for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            bus.stall  = 1'b0;
            bus.opcode = tbl[v].op;
            if (bus.state == 3'd3) begin
               bus.mem_ready = (mc >= tbl[v].mem_lat);
               mc++;
            end else begin
               bus.mem_ready = 1'b1;
            end
            #1;
            ncyc++;
            if (bus.state == 3'd2) ex = dut_ctl();
            if (bus.instr_done) done = 1'b1;
         end
         if (done) n_ret++;
         chk($sformatf("tbl_done_%0d", v), 32'(done), 32'd1);
         chk($sformatf("tbl_cycles_%0d", v), 32'(ncyc), 32'(tbl[v].cycles));
         chk($sformatf("tbl_exec_%0d", v),
             32'({ex.alu_op, ex.alu_src, ex.reg_dst, ex.byte_ops, ex.mv}), 32'(tbl[v].exec_ctl));
      end
      chk_perf("retired_tbl");

      // Stall held 5 cycles in WB of an R-type.
      do_reset();
      cyc(0, OP_R, 1'b1, 1'b0, 1'b0, "st_fetch");
      cyc(1, OP_R, 1'b0, 1'b0, 1'b0, "st_decode");
      cyc(2, OP_R, 1'b0, 1'b0, 1'b0, "st_exec");
      for (int i = 0; i < 5; i++) cyc(4, OP_R, 1'($urandom), 1'b1, 1'b0, "wb_stall");
      cyc(4, OP_R, 1'b0, 1'b0, 1'b0, "wb_release");
      chk_perf("retired_after_stall");
      cyc(0, OP_R, 1'b0, 1'b0, 1'b0, "back_to_fetch");

      // Asynchronous reset in the middle of a sw access.
      do_reset();
      cyc(0, OP_SW, 1'b1, 1'b0, 1'b0, "ar_fetch");
      cyc(1, OP_SW, 1'b0, 1'b0, 1'b0, "ar_decode");
      cyc(2, OP_SW, 1'b0, 1'b0, 1'b0, "ar_exec");
      cyc(3, OP_SW, 1'b0, 1'b0, 1'b0, "ar_mem");
      cyc(3, OP_SW, 1'b0, 1'b0, 1'b0, "ar_mem");
      #2 reset = 1'b1;
      #1 chk("async_reset_mem", 32'(dut_ctl()), 32'(spec_ctl(0, 6'd0, 1'b0, 1'b0, 1'b0)));
      bus.stall = 1'b1;
      @(negedge clk);
      reset = 1'b0; n_ret = 0;

      // Wait-counter boundaries: 15 waits then ready is fine, in FETCH and MEM.
      run_instr(OP_R, 15, 0, 0);
      run_instr(OP_LW, 0, 15, 0);
      run_instr(OP_SB, 15, 15, 0);

      // FETCH timeout: no mem_ready when the counter reaches 15.
      do_reset();
      for (int i = 0; i < 16; i++) cyc(0, OP_R, 1'b0, 1'b0, 1'b0, "to_fetch_wait");
      for (int i = 0; i < 4; i++) cyc(7, OP_R, 1'($urandom), 1'b0, 1'b1, "to_fetch_trap");
      chk_perf("retired_trap_hold");

      // MEM timeout on a store.
      do_reset();
      cyc(0, OP_SW, 1'b1, 1'b0, 1'b0, "tm_fetch");
      cyc(1, OP_SW, 1'b0, 1'b0, 1'b0, "tm_decode");
      cyc(2, OP_SW, 1'b0, 1'b0, 1'b0, "tm_exec");
      for (int i = 0; i < 16; i++) cyc(3, OP_SW, 1'b0, 1'b0, 1'b0, "tm_mem_wait");
      for (int i = 0; i < 3; i++) cyc(7, OP_SW, 1'($urandom), 1'b0, 1'b1, "tm_mem_trap");

      // Illegal opcodes: 111111 and a few random non-members of the opcode map.
      do_reset();
      run_instr(6'b111111, 0, 0, 0);
      for (int n = 0; n < 3; n++) begin
         logic [5:0] bad;
         bad = 6'($urandom);
         while (is_legal(bad)) bad = 6'($urandom);
         do_reset();
         run_instr(bad, int'($urandom_range(0, 3)), 0, 30);
      end

      // Random instruction stream with random latencies and stalls.
      do_reset();
      for (int n = 0; n < 150; n++) begin
         run_instr(legal_ops[$urandom_range(0, 12)], int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), 20);
      end
      chk_perf("retired_random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder. It drives the same control-signal set: regDst, branch, memRead, memWrite, ALUop, ALUsrc, regWrite, jump, byteOperations and move. The difference is that it steps each instruction through a FETCH/DECODE/EXEC/MEM/WB state machine, with a variable-latency memory handshake, a memory timeout, stall support and an illegal-opcode trap. It sits between the instruction register and the datapath of the multi-cycle CPU.

Parameters:
OPCODE_W, 6, opcode width; opcodes listed below are zero-extended to this width.
ALUOP_W, 3, ALUop width; must be >= 3.
MEM_TIMEOUT, 15, maximum wait cycles on mem_ready per access; 0 disables the timeout.
CNT_W, 4, width of the wait counter; must satisfy MEM_TIMEOUT < 2**CNT_W.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous active-high reset.
opcode  in  OPCODE_W  opcode field of the instruction word arriving from memory.
mem_ready  in  1  memory completed the current access.
stall  in  1  freeze; state, wait counter and opcode_q hold, and every write enable is forced to 0.
mem_req  out  1  memory access request.
ir_write  out  1  load the instruction register.
pc_write  out  1  update the PC (PC+4, branch target or jump target, as selected by the datapath).
regDst, branch, memRead, memWrite, ALUsrc, regWrite, jump, byteOperations, move  out  1 each  datapath controls.
ALUop  out  ALUOP_W  ALU operation.
state  out  3  current state, for debug.
illegal  out  1  trap flag; sticky.
timeout  out  1  trap cause: 1 = memory timeout, 0 = illegal opcode.
instr_done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Opcode map: 000000 R-type; 000010 addi; 000011 andi; 000100 ori; 000101 slti; 001000 beq; 001001 bne; 010000 lw; 010001 sw; 010010 lb; 010011 sb; 100000 j; 111000 move. All other opcodes are illegal.
- ALUop encoding: 000 add, 001 sub, 010 funct (R-type), 011 and, 100 or, 101 slt.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Outputs are combinational from state and opcode_q. opcode_q is a register.
- Reset: state=FETCH, wait counter=0, opcode_q=0. All outputs are 0 except those FETCH asserts (mem_req=1, memRead=1).
- FETCH: mem_req=1, memRead=1.
  - On mem_ready: ir_write=1 and pc_write=1 in that cycle; opcode_q<=opcode; go to DECODE.
  - Otherwise the wait counter increments.
- DECODE (1 cycle):
  - Illegal opcode: go to TRAP.
  - j: jump=1, pc_write=1, instr_done=1, go to FETCH.
  - All others: go to EXEC.
- EXEC (1 cycle):
  - ALUsrc=1 for immediate, load and store ops. regDst=1 for R-type and move. byteOperations=1 for lb/sb. move=1 for move.
  - ALUop: add for addi/lw/sw/lb/sb/move; sub for beq/bne.
  - beq/bne: branch=1, pc_write=1 (the datapath qualifies it with zero/!zero), instr_done=1, go to FETCH.
  - Loads and stores: go to MEM.
  - All others: go to WB.
- MEM: mem_req=1; memRead=1 for lw/lb, memWrite=1 for sw/sb; byteOperations held for lb/sb.
  - On mem_ready, loads go to WB.
  - On mem_ready, stores pulse instr_done and go to FETCH.
- WB (1 cycle): regWrite=1, regDst as in EXEC, instr_done=1, go to FETCH.
- Wait counter:
  - Cleared on every state change.
  - Counts cycles in FETCH or MEM without mem_ready.
  - If MEM_TIMEOUT != 0 and the counter equals MEM_TIMEOUT without mem_ready: go to TRAP with timeout=1.
  - mem_ready on that same cycle wins, so no trap occurs.
- TRAP: illegal=1; all enables and mem_req are 0; remains in TRAP until reset.
- stall=1: holds everything, forces ir_write, pc_write, regWrite and memWrite to 0, and forces instr_done to 0. mem_ready is ignored while stalled.
- Asynchronous reset mid-access: mem_req drops immediately; the next state is FETCH.

Optional Feature:
MCU_PERF_CNT_EN:
- Enabled: adds output retired_cnt (32 bits), incremented on each instr_done pulse. It wraps 0xFFFFFFFF->0, is cleared by reset, and holds in TRAP.
- Disabled: the port and counter are absent.

Test Plan:
- Reset asserted mid-MEM of sw with mem_ready=0 -> state=0, mem_req=1, memRead=1, memWrite=0 in the same cycle.
- R-type (000000) with mem_ready held high -> states 0,1,2,4,0. In EXEC ALUop=010, regDst=1. In WB regWrite=1, instr_done=1. Total 4 cycles.
- lw (010000), mem_ready delayed 3 cycles in MEM -> memRead=1, ALUsrc=1 for 3+1 cycles, then WB regWrite=1. sw (010001) -> memWrite=1, no WB, instr_done on the mem_ready cycle.
- beq (001000) -> EXEC: branch=1, ALUop=001, pc_write=1. j (100000) -> DECODE: jump=1, retires in 2 cycles.
- Opcode 111111 -> TRAP, illegal=1, timeout=0, all enables 0 for 20 cycles. With MEM_TIMEOUT=15 and mem_ready never asserted in FETCH -> TRAP after 15 wait cycles with timeout=1. mem_ready on cycle 15 -> no trap.
- stall=1 for 5 cycles in WB -> regWrite=0 and state=4 held. After release, regWrite=1 for one cycle. With MCU_PERF_CNT_EN, retired_cnt=1.
